thumb_fetch: RTL and testbench

//  Instruction fetch stage feeding the Thumb decoder. Reads 32-bit words from

---
 rtl/thumb_pkg.sv | 30 +++
 rtl/thumb_hw_queue.sv | 56 +++++
 rtl/thumb_fetch.sv | 143 ++++++++++++++
 tb/tb_thumb_fetch.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/thumb_pkg.sv
// thumb_pkg: shared definitions for the Thumb fetch slice.
//   - register indices for PC/LR/SP
//   - halfword width and the three 32-bit instruction prefixes
//   - fetch FSM state encoding
//   - is_thumb32(): classifies a first halfword as a 32-bit prefix
package thumb_pkg;

    localparam int unsigned HW_W   = 16;

    localparam int unsigned REG_PC = 15;
    localparam int unsigned REG_LR = 14;
    localparam int unsigned REG_SP = 13;

    localparam logic [4:0] T32_PFX_A = 5'b11101;
    localparam logic [4:0] T32_PFX_B = 5'b11110;
    localparam logic [4:0] T32_PFX_C = 5'b11111;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    function automatic logic is_thumb32(input logic [HW_W-1:0] hw);
        return (hw[HW_W-1 -: 5] == T32_PFX_A) ||
               (hw[HW_W-1 -: 5] == T32_PFX_B) ||
               (hw[HW_W-1 -: 5] == T32_PFX_C);
    endfunction

endpackage

// File: rtl/thumb_hw_queue.sv
// thumb_hw_queue: QDEPTH x 16-bit circular halfword FIFO.
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   flush         : synchronous empty (drops everything, ignores push/pop)
//   push_n        : number of halfwords written this cycle (0..2), d0 first
//   push_d0/d1    : halfwords to write
//   pop_n         : number of halfwords removed from the head (0..2)
//   count         : halfwords currently held
//   head0/head1   : oldest and second-oldest halfword
// The caller guarantees count - pop_n + push_n never exceeds QDEPTH.
import thumb_pkg::*;

module thumb_hw_queue #(
    parameter int unsigned QDEPTH = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [1:0]                push_n,
    input  logic [HW_W-1:0]           push_d0,
    input  logic [HW_W-1:0]           push_d1,
    input  logic [1:0]                pop_n,
    output logic [$clog2(QDEPTH):0]   count,
    output logic [HW_W-1:0]           head0,
    output logic [HW_W-1:0]           head1
);

    localparam int unsigned PW = $clog2(QDEPTH);

    logic [HW_W-1:0] slots [QDEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push_n);
            rd_ptr <= rd_ptr + PW'(pop_n);
            count  <= count + (PW+1)'(push_n) - (PW+1)'(pop_n);
        end
    end

    // Storage carries no reset; pointers alone define what is valid.
    always_ff @(posedge clock) begin
        if (!flush) begin
            if (push_n != 2'd0) slots[wr_ptr]          <= push_d0;
            if (push_n == 2'd2) slots[wr_ptr + PW'(1)] <= push_d1;
        end
    end

    assign head0 = slots[rd_ptr];
    assign head1 = slots[rd_ptr + PW'(1)];

endmodule

// File: rtl/thumb_fetch.sv
// thumb_fetch: Thumb instruction fetch stage.
// Reads 32-bit words from word-addressed instruction memory, splits them into
// halfwords through a small queue and presents one 16- or 32-bit instruction
// at a time to the decoder. Execute can redirect the PC at any time.
//   clock, reset    : rising-edge clock, synchronous active-high reset
//   mem_req/addr    : word read request / word address (held until mem_ack)
//   mem_ack/rdata   : request accepted, read data valid in the same cycle
//   redirect_valid  : 1-cycle pulse, new fetch target in redirect_pc
//   instr_valid/ready, instr, instr_is32, instr_pc, instr_pc4 : decoder side
import thumb_pkg::*;

module thumb_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic              instr_is32,
    output logic [31:0]       instr_pc,
    output logic [31:0]       instr_pc4
);

    localparam int unsigned CW = $clog2(QDEPTH) + 1;

    fetch_state_e      state, state_n;
    logic [ADDR_W-1:0] fetch_word;
    logic [ADDR_W-1:0] req_word;
    logic              drop_first;
    logic [31:0]       pc_q;

    logic [CW-1:0]     q_count;
    logic [HW_W-1:0]   hw0, hw1;
    logic [1:0]        push_n, pop_n;
    logic [HW_W-1:0]   push_d0, push_d1;

    logic              has_room;
    logic              req_int;
    logic              accept;
    logic              consume;
    logic              head_is32;

    thumb_hw_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clock   (clock),
        .reset   (reset),
        .flush   (redirect_valid),
        .push_n  (push_n),
        .push_d0 (push_d0),
        .push_d1 (push_d1),
        .pop_n   (pop_n),
        .count   (q_count),
        .head0   (hw0),
        .head1   (hw1)
    );

    // A request is only launched with room for a whole word; since at most one
    // request is outstanding, the ack can always be pushed.
    assign has_room = (q_count <= CW'(QDEPTH - 2));

    always_ff @(posedge clock) begin
        if (reset) state <= ST_RUN;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        req_int = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (has_room) begin
                    req_int = 1'b1;
                    if (!mem_ack) state_n = redirect_valid ? ST_DRAIN : ST_WAIT;
                end
            end
            ST_WAIT: begin
                req_int = 1'b1;
                if (mem_ack)             state_n = ST_RUN;
                else if (redirect_valid) state_n = ST_DRAIN;
            end
            ST_DRAIN: begin
                req_int = 1'b1;
                if (mem_ack) state_n = ST_RUN;
            end
            default: state_n = ST_RUN;
        endcase
    end

    always_comb begin
        // Reset abandons any request immediately, not one cycle later.
        mem_req   = req_int && !reset;
        // RUN presents the live fetch address; WAIT/DRAIN hold the one issued,
        // even if a redirect has since moved fetch_word.
        mem_addr  = (state == ST_RUN) ? fetch_word : req_word;

        accept    = req_int && mem_ack && !redirect_valid && (state != ST_DRAIN);
        push_n    = accept ? (drop_first ? 2'd1 : 2'd2) : 2'd0;
        push_d0   = drop_first ? mem_rdata[31:16] : mem_rdata[15:0];
        push_d1   = mem_rdata[31:16];

        head_is32   = is_thumb32(hw0);
        instr_valid = head_is32 ? (q_count >= CW'(2)) : (q_count >= CW'(1));
        consume     = instr_valid && instr_ready && !redirect_valid;
        pop_n       = consume ? (head_is32 ? 2'd2 : 2'd1) : 2'd0;

        instr       = '0;
        if (instr_valid) instr = head_is32 ? {hw0, hw1} : {16'h0000, hw0};
        instr_is32  = (q_count != '0) && head_is32;
        instr_pc    = pc_q;
        instr_pc4   = pc_q + 32'd4;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_word <= RESET_PC[ADDR_W+1:2];
            drop_first <= RESET_PC[1];
            pc_q       <= RESET_PC;
            req_word   <= '0;
        end else begin
            if (state == ST_RUN) req_word <= fetch_word;
            if (redirect_valid) begin
                fetch_word <= redirect_pc[ADDR_W+1:2];
                drop_first <= redirect_pc[1];
                pc_q       <= redirect_pc & 32'hFFFF_FFFE;
            end else begin
                if (accept) begin
                    fetch_word <= fetch_word + ADDR_W'(1);
                    drop_first <= 1'b0;
                end
                if (consume) pc_q <= pc_q + (head_is32 ? 32'd4 : 32'd2);
            end
        end
    end

endmodule

// File: tb/tb_thumb_fetch.sv
// tb_thumb_fetch: self-checking bench for thumb_fetch.
// A behavioural memory responder acks with 0/1/5-cycle delays; a reference
// model walks the program in byte-address order from the current PC and
// predicts every presented instruction.
module tb_thumb_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned QDEPTH   = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic              instr_is32;
    logic [31:0]       instr_pc;
    logic [31:0]       instr_pc4;

    always #5 clock = ~clock;

    thumb_fetch #(
        .RESET_PC (RESET_PC),
        .ADDR_W   (ADDR_W),
        .QDEPTH   (QDEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_is32     (instr_is32),
        .instr_pc       (instr_pc),
        .instr_pc4      (instr_pc4)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // memory image and responder state
    logic [31:0]       mem_img [1024];
    int unsigned       delay_mode;
    logic              busy;
    int unsigned       wait_cnt;
    logic [ADDR_W-1:0] hold_addr;
    logic              acked_now;
    logic [ADDR_W-1:0] ack_addr_now;
    logic [ADDR_W-1:0] ack_log [$];

    // reference model state
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
        logic        is32;
        logic [31:0] pc4;
    } rec_t;
    rec_t        got_log [$];
    logic [31:0] exp_pc;
    logic        expect_idle;
    int unsigned idle;
    int unsigned idle_max;

    function automatic logic [15:0] hw_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem_img[a[ADDR_W+1:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic logic wants_pair(input logic [15:0] h);
        return (h[15:13] == 3'b111) && (h[12:11] != 2'b00);
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 3) == 0) w[15:11] = 5'b11110;
        if ($urandom_range(0, 3) == 0) w[31:27] = 5'b11111;
        return w;
    endfunction

    function automatic int unsigned pick_delay();
        int unsigned r;
        if (delay_mode == 0) return 0;
        if (delay_mode == 2) return 5;
        r = $urandom_range(0, 2);
        return (r == 0) ? 0 : (r == 1) ? 1 : 5;
    endfunction

    task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc);
        logic [15:0] h0;
        logic        pair;
        logic [31:0] want;
        @(negedge clock);
        acked_now = 1'b0;
        if (!mem_req) begin
            busy      = 1'b0;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
        end else begin
            if (!busy) begin
                busy      = 1'b1;
                hold_addr = mem_addr;
                wait_cnt  = pick_delay();
            end else begin
                check("addr_hold", 32'(mem_addr), 32'(hold_addr));
            end
            if (wait_cnt == 0) begin
                mem_ack      = 1'b1;
                mem_rdata    = mem_img[mem_addr];
                busy         = 1'b0;
                acked_now    = 1'b1;
                ack_addr_now = mem_addr;
                ack_log.push_back(mem_addr);
            end else begin
                wait_cnt--;
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end
        end
        instr_ready    = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        #1;
        if (expect_idle) check("valid_after_redirect", 32'(instr_valid), 32'd0);
        expect_idle = 1'b0;
        check("pc", instr_pc, exp_pc);
        check("pc4", instr_pc4, exp_pc + 32'd4);
        h0   = hw_at(exp_pc);
        pair = wants_pair(h0);
        if (instr_valid) begin
            want = pair ? {h0, hw_at(exp_pc + 32'd2)} : {16'h0000, h0};
            check("instr", instr, want);
            check("is32", 32'(instr_is32), 32'(pair));
        end
        if (redir) begin
            exp_pc      = rpc & 32'hFFFF_FFFE;
            expect_idle = 1'b1;
            idle        = 0;
        end else if (instr_valid && rdy) begin
            got_log.push_back('{instr_pc, instr, instr_is32, instr_pc4});
            exp_pc = exp_pc + (pair ? 32'd4 : 32'd2);
            idle   = 0;
        end else if (rdy) begin
            idle++;
            if (idle > idle_max) idle_max = idle;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset          = 1'b1;
        mem_ack        = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        busy           = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check("rst_req",   32'(mem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_is32",  32'(instr_is32), 32'd0);
        check("rst_pc",    instr_pc, RESET_PC);
        check("rst_pc4",   instr_pc4, RESET_PC + 32'd4);
        reset       = 1'b0;
        exp_pc      = RESET_PC;
        expect_idle = 1'b0;
        idle        = 0;
        ack_log.delete();
        got_log.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n0;
        logic        found;
        logic        wait6;
        logic        seen1;
        logic        rdy, redir;
        logic [31:0] rpc;

        reset = 1'b1; mem_ack = 1'b0; mem_rdata = '0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; busy = 1'b0; wait_cnt = 0;
        hold_addr = '0; acked_now = 1'b0; ack_addr_now = '0; delay_mode = 0;
        exp_pc = RESET_PC; expect_idle = 1'b0; idle = 0; idle_max = 0;
        for (int i = 0; i < 1024; i++) mem_img[i] = rand_word();
        mem_img[0] = 32'h3001_2002;
        mem_img[1] = 32'hF800_F000;

        // 16-bit pair from word 0, then 32-bit pair from word 1
        do_reset();
        delay_mode = 0;
        for (int k = 0; k < 40 && got_log.size() < 4; k++) step(1'b1, 1'b0, 32'h0);
        check("t1_count", 32'(got_log.size() >= 4), 32'd1);
        if (got_log.size() >= 4) begin
            check("t1_pc0",    got_log[0].pc,   32'h0);
            check("t1_instr0", got_log[0].word, 32'h0000_2002);
            check("t1_pc4_0",  got_log[0].pc4,  32'h4);
            check("t1_pc1",    got_log[1].pc,   32'h2);
            check("t1_instr1", got_log[1].word, 32'h0000_3001);
            check("t1_pc4_1",  got_log[1].pc4,  32'h6);
            check("t2_pc",     got_log[2].pc,   32'h4);
            check("t2_instr",  got_log[2].word, 32'hF000_F800);
            check("t2_is32",   32'(got_log[2].is32), 32'd1);
            check("t2_next",   got_log[3].pc,   32'h8);
        end

        // decoder stall fills the queue and stops requests
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 32'h0);
        check("t4_req_off", 32'(mem_req), 32'd0);
        n0 = got_log.size();
        for (int k = 0; k < 40; k++) step(1'b1, 1'b0, 32'h0);
        check("t4_resume", 32'(got_log.size() > n0 + 4), 32'd1);

        // redirect to 0x12 while waiting on word 2
        mem_img[4] = 32'h1234_5678;
        do_reset();
        delay_mode = 2;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            step(1'b1, 1'b0, 32'h0);
            if (busy && hold_addr == ADDR_W'(2) && wait_cnt != 0) found = 1'b1;
        end
        check("t3_reach", 32'(found), 32'd1);
        ack_log.delete();
        n0 = got_log.size();
        step(1'b1, 1'b1, 32'h0000_0012);
        for (int k = 0; k < 100 && got_log.size() == n0; k++) step(1'b1, 1'b0, 32'h0);
        check("t3_acks", 32'(ack_log.size() >= 2), 32'd1);
        if (ack_log.size() >= 2) begin
            check("t3_drain_addr", 32'(ack_log[0]), 32'd2);
            check("t3_next_addr",  32'(ack_log[1]), 32'd4);
        end
        check("t3_got", 32'(got_log.size() > n0), 32'd1);
        if (got_log.size() > n0) begin
            check("t3_pc",    got_log[n0].pc,   32'h12);
            check("t3_instr", got_log[n0].word, 32'h0000_1234);
        end

        // BL prefix at 0x6 whose suffix lives in the next word
        mem_img[1] = 32'hF00A_1111;
        mem_img[2] = 32'h2222_F800;
        do_reset();
        delay_mode = 2;
        step(1'b1, 1'b1, 32'h0000_0006);
        wait6 = 1'b0;
        seen1 = 1'b0;
        for (int k = 0; k < 100 && got_log.size() == 0; k++) begin
            step(1'b1, 1'b0, 32'h0);
            if (wait6) check("t6_hold", 32'(instr_valid), 32'd0);
            if (acked_now && ack_addr_now == ADDR_W'(1)) begin wait6 = 1'b1; seen1 = 1'b1; end
            if (acked_now && ack_addr_now == ADDR_W'(2)) wait6 = 1'b0;
        end
        check("t6_word1", 32'(seen1), 32'd1);
        check("t6_got", 32'(got_log.size() > 0), 32'd1);
        if (got_log.size() > 0) begin
            check("t6_pc",    got_log[0].pc,   32'h6);
            check("t6_is32",  32'(got_log[0].is32), 32'd1);
            check("t6_instr", got_log[0].word, 32'hF00A_F800);
        end

        // random traffic: delays 0/1/5, random ready, redirects incl. wrap region
        for (int i = 0; i < 16; i++) mem_img[i] = rand_word();
        do_reset();
        delay_mode = 1;
        idle_max   = 0;
        for (int k = 0; k < 4000; k++) begin
            if (k == 2000) begin
                for (int j = 0; j < 20 && !busy; j++) step(1'b1, 1'b0, 32'h0);
                do_reset();
                delay_mode = 1;
            end
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 49) == 0);
            rpc   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                : ($urandom & 32'h0000_0FFF);
            step(rdy, redir, rpc);
        end
        check("t5_progress", 32'(idle_max <= 60), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
